mem_xbar: RTL and testbench
===========================

// Module: mem_xbar
// PURPOSE
//  NM-master x NS-slave memory crossbar for the SoC, sitting between the cpu ports (imemory, dmemory, ...) and peripherals (bram, print, clint, ...).
//  Replaces the fixed 2x3 decoder with a parametrised address map, per-slave round-robin arbitration and per-master request buffering, so a losing request is held, not dropped.
//  Decode misses return an error response instead of hanging the master.
// PARAMETERS
//  NM        2             number of masters (index 0 = highest priority after reset)
//  NS        3             number of slaves
//  AW        32            address width
//  DW        32            data width; strobe width DW/8
//  SLV_BASE  {NS{AW'h0}}   packed per-slave base address; slave i uses bits [i*AW +: AW]
//  SLV_MASK  {NS{AW'h0}}   packed per-slave decode mask; hit_i = ((addr & MASK_i) == BASE_i)
//  ALIAS_EN  0             1 enables single-address alias (host/tohost)
//  ALIAS_ADR 0             alias address; routed to slave ALIAS_SLV with slave address ALIAS_ADR - BASE
//  ALIAS_SLV 0             alias target slave index
//  ERR_DATA  32'hDEADBEEF  rdata returned on decode miss
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        synchronous, active-high
//  m_valid    in   NM       per-master request pulse (one cycle)
//  m_instr    in   NM       instruction-fetch qualifier
//  m_addr     in   NM*AW    request address
//  m_wdata    in   NM*DW    write data
//  m_wstrb    in   NM*DW/8  byte strobes; 0 = read
//  m_rdata    out  NM*DW    response data, valid with m_ready
//  m_ready    out  NM       response pulse
//  m_err      out  NM       decode-miss flag, valid with m_ready
//  s_valid    out  NS       per-slave request pulse
//  s_instr    out  NS       forwarded instr
//  s_addr     out  NS*AW    address minus slave base
//  s_wdata    out  NS*DW    forwarded write data
//  s_wstrb    out  NS*DW/8  forwarded strobes
//  s_rdata    in   NS*DW    slave response data
//  s_ready    in   NS       slave response pulse
// BEHAVIOUR
//  Decode: lowest-index hitting slave wins; alias has priority when ALIAS_EN and addr == ALIAS_ADR; no hit = miss.
//  Master FSM per master, states IDLE, PEND, OUT, ERR:
//   IDLE: m_valid hit -> granted this cycle ? OUT : PEND (addr/instr/wdata/wstrb/target latched). m_valid miss -> ERR.
//   PEND: request re-presented to arbiter each cycle from latch; grant -> OUT.
//   OUT : wait for s_ready of owning slave; that cycle m_ready=1, m_rdata=s_rdata (combinational), -> IDLE.
//   ERR : m_ready=1, m_err=1, m_rdata=ERR_DATA for one cycle, -> IDLE (miss latency 1 cycle).
//   m_valid is accepted only in IDLE or in the cycle m_ready=1 (back-to-back); otherwise ignored.
//  Slave side per slave: busy flag + owner index.
//   Free slave arbitrates among masters whose live (IDLE) or latched (PEND) request targets it.
//   Round-robin: pointer = last granted master; search starts at pointer+1 mod NM; reset pointer = NM-1.
//   Grant drives s_valid=1 for exactly one cycle with the selected fields, s_addr = addr - BASE; sets busy/owner.
//   s_ready from the owner clears busy; a new grant is allowed in that same cycle (back-to-back).
//   s_ready while not busy is ignored.
//  Latency: uncontended request reaches slave in the same cycle (0 added); response is combinational (0 added).
//  Simultaneous: two masters to the same free slave -> one granted, the other PEND, granted on the first free cycle.
//   Masters to different slaves proceed in parallel.
//  Reset (also mid-transaction): all FSMs IDLE, latches cleared, busy=0, pointers=NM-1.
//   Outputs s_valid, s_* fields, m_ready, m_err, m_rdata = 0 while reset=1; late slave responses are discarded.
// TESTING
//  NM=2,NS=3 map {0x0,mask 0xFFF00000},{0x02000000,mask 0xFFFF0000},{0x10000000,mask 0xFFFFF000}.
//  m0 read 0x00000100, bram ready +1 -> s_valid[0] same cycle, s_addr=0x100; m_ready[0] next cycle with rdata.
//  m0,m1 both hit slave 0 same cycle -> m0 granted, m1 PEND; m1 s_valid on the s_ready cycle; next tie -> m1 wins.
//  m0->slave 1, m1->slave 2 same cycle -> both s_valid same cycle; s_addr = addr - base.
//  m1 read 0x30000000 (miss) -> next cycle m_ready[1]=1, m_err[1]=1, m_rdata=DEADBEEF; no s_valid.
//  ALIAS_EN=1, ALIAS_ADR=0x80001000 -> routed to ALIAS_SLV. Reset asserted while OUT -> all outputs 0; following s_ready ignored.

Source files
------------

// File: rtl/mem_xbar.sv
// mem_xbar: NM x NS memory crossbar with address decode, per-slave round-robin arbitration and per-master request buffering
module mem_xbar #(
  parameter int NM = 2,
  parameter int NS = 3,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [NS*AW-1:0] SLV_BASE = '0,
  parameter logic [NS*AW-1:0] SLV_MASK = '0,
  parameter bit ALIAS_EN = 1'b0,
  parameter logic [AW-1:0] ALIAS_ADR = '0,
  parameter int ALIAS_SLV = 0,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NM-1:0]      m_valid,
  input  logic [NM-1:0]      m_instr,
  input  logic [NM*AW-1:0]   m_addr,
  input  logic [NM*DW-1:0]   m_wdata,
  input  logic [NM*DW/8-1:0] m_wstrb,
  output logic [NM*DW-1:0]   m_rdata,
  output logic [NM-1:0]      m_ready,
  output logic [NM-1:0]      m_err,
  output logic [NS-1:0]      s_valid,
  output logic [NS-1:0]      s_instr,
  output logic [NS*AW-1:0]   s_addr,
  output logic [NS*DW-1:0]   s_wdata,
  output logic [NS*DW/8-1:0] s_wstrb,
  input  logic [NS*DW-1:0]   s_rdata,
  input  logic [NS-1:0]      s_ready
);
  localparam int SB = DW/8;
  localparam int MW = NM > 1 ? $clog2(NM) : 1;
  localparam int SW = NS > 1 ? $clog2(NS) : 1;
  typedef enum logic [1:0] {IDLE, PEND, OUT, ERR} state_t;
  state_t        st_q  [NM];
  state_t        st_d  [NM];
  logic [SW-1:0] tgt_q [NM];
  logic [SW-1:0] tgt_d [NM];
  logic [AW-1:0] adr_q [NM];
  logic [AW-1:0] adr_d [NM];
  logic [DW-1:0] wd_q  [NM];
  logic [DW-1:0] wd_d  [NM];
  logic [SB-1:0] ws_q  [NM];
  logic [SB-1:0] ws_d  [NM];
  logic [NM-1:0] ins_q, ins_d;
  logic [NS-1:0] busy_q, busy_d;
  logic [MW-1:0] ptr_q [NS];
  logic [MW-1:0] ptr_d [NS];
  logic [NM-1:0] hit, acc, resp, rq, gnt, rins;
  logic [SW-1:0] dtgt [NM];
  logic [SW-1:0] rtgt [NM];
  logic [AW-1:0] dadr [NM];
  logic [AW-1:0] radr [NM];
  logic [DW-1:0] rwd  [NM];
  logic [SB-1:0] rws  [NM];
  logic [NS-1:0] sgnt;
  logic [MW-1:0] sel  [NS];
  int rr_idx;
  // Address decode: lowest-index hit wins, alias overrides; slave-relative address from the chosen base
  always_comb begin
    for (int m = 0; m < NM; m++) begin
      hit[m] = 1'b0;
      dtgt[m] = '0;
      for (int s = NS-1; s >= 0; s--) begin
        if ((m_addr[m*AW +: AW] & SLV_MASK[s*AW +: AW]) == SLV_BASE[s*AW +: AW]) begin
          hit[m] = 1'b1;
          dtgt[m] = SW'(s);
        end
      end
      if (ALIAS_EN && m_addr[m*AW +: AW] == ALIAS_ADR) begin
        hit[m] = 1'b1;
        dtgt[m] = SW'(ALIAS_SLV);
      end
      dadr[m] = m_addr[m*AW +: AW] - SLV_BASE[dtgt[m]*AW +: AW];
    end
  end
  // Request presented to arbiters: live request when accepted, latched one while pending
  always_comb begin
    for (int m = 0; m < NM; m++) begin
      resp[m] = st_q[m] == ERR || (st_q[m] == OUT && s_ready[tgt_q[m]]);
      acc[m] = m_valid[m] && (st_q[m] == IDLE || resp[m]);
      rq[m] = (acc[m] && hit[m]) || st_q[m] == PEND;
      rtgt[m] = st_q[m] == PEND ? tgt_q[m] : dtgt[m];
      radr[m] = st_q[m] == PEND ? adr_q[m] : dadr[m];
      rwd[m] = st_q[m] == PEND ? wd_q[m] : m_wdata[m*DW +: DW];
      rws[m] = st_q[m] == PEND ? ws_q[m] : m_wstrb[m*SB +: SB];
      rins[m] = st_q[m] == PEND ? ins_q[m] : m_instr[m];
    end
  end
  // Per-slave round-robin: search starts after the last granted master; a slave freed by s_ready regrants at once
  always_comb begin
    rr_idx = 0;
    for (int s = 0; s < NS; s++) begin
      sgnt[s] = 1'b0;
      sel[s] = '0;
      for (int k = 1; k <= NM; k++) begin
        rr_idx = (int'(ptr_q[s]) + k) % NM;
        if (!sgnt[s] && (!busy_q[s] || s_ready[s]) && rq[rr_idx] && rtgt[rr_idx] == SW'(s)) begin
          sgnt[s] = 1'b1;
          sel[s] = MW'(rr_idx);
        end
      end
    end
  end
  // Master FSMs, request latches and slave busy/pointer next state
  always_comb begin
    for (int m = 0; m < NM; m++) begin
      gnt[m] = rq[m] && sgnt[rtgt[m]] && sel[rtgt[m]] == MW'(m);
      st_d[m] = gnt[m] ? OUT : acc[m] ? (hit[m] ? PEND : ERR) : resp[m] ? IDLE : st_q[m];
      tgt_d[m] = acc[m] ? dtgt[m] : tgt_q[m];
      adr_d[m] = acc[m] ? dadr[m] : adr_q[m];
      wd_d[m] = acc[m] ? m_wdata[m*DW +: DW] : wd_q[m];
      ws_d[m] = acc[m] ? m_wstrb[m*SB +: SB] : ws_q[m];
      ins_d[m] = acc[m] ? m_instr[m] : ins_q[m];
    end
    for (int s = 0; s < NS; s++) begin
      busy_d[s] = sgnt[s] || (busy_q[s] && !s_ready[s]);
      ptr_d[s] = sgnt[s] ? sel[s] : ptr_q[s];
    end
  end
  // Outputs: granted master's fields to slaves, responses to masters; all forced to zero during reset
  always_comb begin
    s_valid = '0;
    s_instr = '0;
    s_addr = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_ready = '0;
    m_err = '0;
    m_rdata = '0;
    for (int s = 0; s < NS; s++) begin
      if (!reset && sgnt[s]) begin
        s_valid[s] = 1'b1;
        s_instr[s] = rins[sel[s]];
        s_addr[s*AW +: AW] = radr[sel[s]];
        s_wdata[s*DW +: DW] = rwd[sel[s]];
        s_wstrb[s*SB +: SB] = rws[sel[s]];
      end
    end
    for (int m = 0; m < NM; m++) begin
      if (!reset && resp[m]) begin
        m_ready[m] = 1'b1;
        m_err[m] = st_q[m] == ERR;
        m_rdata[m*DW +: DW] = st_q[m] == ERR ? ERR_DATA : s_rdata[tgt_q[m]*DW +: DW];
      end
    end
  end
  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int m = 0; m < NM; m++) begin
        st_q[m] <= IDLE;
        tgt_q[m] <= '0;
        adr_q[m] <= '0;
        wd_q[m] <= '0;
        ws_q[m] <= '0;
      end
      for (int s = 0; s < NS; s++) ptr_q[s] <= MW'(NM-1);
      ins_q <= '0;
      busy_q <= '0;
    end else begin
      for (int m = 0; m < NM; m++) begin
        st_q[m] <= st_d[m];
        tgt_q[m] <= tgt_d[m];
        adr_q[m] <= adr_d[m];
        wd_q[m] <= wd_d[m];
        ws_q[m] <= ws_d[m];
      end
      for (int s = 0; s < NS; s++) ptr_q[s] <= ptr_d[s];
      ins_q <= ins_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_mem_xbar.sv
// tb_mem_xbar: directed scenarios plus randomized rounds checked against a transaction-level crossbar model
module tb_mem_xbar;
  localparam int NM = 2;
  localparam int NS = 3;
  localparam logic [31:0] ALIAS = 32'h80001000;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;
  logic [31:0] base [NS] = '{32'h00000000, 32'h02000000, 32'h10000000};
  logic [31:0] mask [NS] = '{32'hFFF00000, 32'hFFFF0000, 32'hFFFFF000};
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NM-1:0] m_valid, m_instr, m_ready, m_err;
  logic [NM*32-1:0] m_addr, m_wdata, m_rdata;
  logic [NM*4-1:0] m_wstrb;
  logic [NS-1:0] s_valid, s_instr, s_ready;
  logic [NS*32-1:0] s_addr, s_wdata, s_rdata;
  logic [NS*4-1:0] s_wstrb;
  int checks = 0;
  int errors = 0;
  int ptr [NS];

  mem_xbar #(
    .NM(NM), .NS(NS), .AW(32), .DW(32),
    .SLV_BASE({32'h10000000, 32'h02000000, 32'h00000000}),
    .SLV_MASK({32'hFFFFF000, 32'hFFFF0000, 32'hFFF00000}),
    .ALIAS_EN(1'b1), .ALIAS_ADR(ALIAS), .ALIAS_SLV(1), .ERR_DATA(ERRD)
  ) dut (
    .clock(clock), .reset(reset),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  always #5 clock = ~clock;

  task automatic next_cycle();
    @(negedge clock);
    m_valid = '0;
    s_ready = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int s = 0; s < NS; s++) ptr[s] = NM-1;
  endtask

  task automatic test_reset();
    next_cycle();
    m_valid = 2'b01; m_addr[31:0] = 32'h100; s_ready = 3'b001; s_rdata[31:0] = 32'h11;
    #1 checks++;
    if ({s_valid, m_ready, m_err, m_rdata, s_addr, s_wdata, s_wstrb, s_instr} !== '0) begin
      errors++; $display("FAIL reset_outputs: got sv=%b mr=%b me=%b rd=%h sa=%h want all 0", s_valid, m_ready, m_err, m_rdata, s_addr);
    end
    next_cycle();
    reset = 1'b0;
    #1 checks++;
    if ({s_valid, m_ready, m_err, m_rdata} !== '0) begin
      errors++; $display("FAIL reset_idle: got sv=%b mr=%b me=%b rd=%h want all 0", s_valid, m_ready, m_err, m_rdata);
    end
    for (int s = 0; s < NS; s++) ptr[s] = NM-1;
  endtask

  task automatic test_single_read();
    do_reset();
    next_cycle();
    m_valid = 2'b01; m_addr[31:0] = 32'h00000100; m_wstrb = '0; m_instr = '0;
    #1 checks++;
    if ({s_valid, s_addr[31:0], m_ready} !== {3'b001, 32'h100, 2'b00}) begin
      errors++; $display("FAIL single_req: got sv=%b sa=%h mr=%b want sv=001 sa=00000100 mr=00", s_valid, s_addr[31:0], m_ready);
    end
    next_cycle();
    s_ready = 3'b001; s_rdata[31:0] = 32'h12345678;
    #1 checks++;
    if ({m_ready, m_err, m_rdata[31:0], s_valid} !== {2'b01, 2'b00, 32'h12345678, 3'b000}) begin
      errors++; $display("FAIL single_resp: got mr=%b me=%b rd=%h sv=%b want mr=01 me=00 rd=12345678 sv=000", m_ready, m_err, m_rdata[31:0], s_valid);
    end
    next_cycle();
    #1 checks++;
    if ({m_ready, s_valid} !== 5'b0) begin
      errors++; $display("FAIL single_after: got mr=%b sv=%b want 0", m_ready, s_valid);
    end
  endtask

  task automatic test_contention();
    do_reset();
    next_cycle();
    m_valid = 2'b11; m_addr = {32'h300, 32'h200}; m_wstrb = '0;
    #1 checks++;
    if ({s_valid, s_addr[31:0]} !== {3'b001, 32'h200}) begin
      errors++; $display("FAIL tie_first: got sv=%b sa=%h want sv=001 sa=00000200", s_valid, s_addr[31:0]);
    end
    next_cycle();
    #1 checks++;
    if ({s_valid, m_ready} !== 5'b0) begin
      errors++; $display("FAIL tie_wait: got sv=%b mr=%b want 0", s_valid, m_ready);
    end
    next_cycle();
    s_ready = 3'b001; s_rdata[31:0] = 32'hA1; m_valid = 2'b01; m_addr[31:0] = 32'h400;
    #1 checks++;
    if ({m_ready, m_rdata[31:0], s_valid, s_addr[31:0]} !== {2'b01, 32'hA1, 3'b001, 32'h300}) begin
      errors++; $display("FAIL tie_handoff: got mr=%b rd=%h sv=%b sa=%h want mr=01 rd=a1 sv=001 sa=300", m_ready, m_rdata[31:0], s_valid, s_addr[31:0]);
    end
    next_cycle();
    s_ready = 3'b001; s_rdata[31:0] = 32'hB2;
    #1 checks++;
    if ({m_ready, m_rdata[63:32], s_valid, s_addr[31:0]} !== {2'b10, 32'hB2, 3'b001, 32'h400}) begin
      errors++; $display("FAIL back_to_back: got mr=%b rd=%h sv=%b sa=%h want mr=10 rd=b2 sv=001 sa=400", m_ready, m_rdata[63:32], s_valid, s_addr[31:0]);
    end
    next_cycle();
    s_ready = 3'b001; s_rdata[31:0] = 32'hC3;
    #1 checks++;
    if ({m_ready, m_rdata[31:0], s_valid} !== {2'b01, 32'hC3, 3'b000}) begin
      errors++; $display("FAIL tie_last: got mr=%b rd=%h sv=%b want mr=01 rd=c3 sv=000", m_ready, m_rdata[31:0], s_valid);
    end
  endtask

  task automatic test_parallel();
    do_reset();
    next_cycle();
    m_valid = 2'b11; m_addr = {32'h10000020, 32'h02000010};
    m_wdata = {32'h0, 32'hA5A5}; m_wstrb = 8'h0F; m_instr = 2'b10;
    #1 checks++;
    if ({s_valid, s_instr} !== {3'b110, 3'b100}) begin
      errors++; $display("FAIL par_valid: got sv=%b si=%b want sv=110 si=100", s_valid, s_instr);
    end
    checks++;
    if ({s_addr[63:32], s_wdata[63:32], s_wstrb[7:4], s_addr[95:64], s_wstrb[11:8]} !== {32'h10, 32'hA5A5, 4'hF, 32'h20, 4'h0}) begin
      errors++; $display("FAIL par_fields: got sa1=%h wd1=%h ws1=%h sa2=%h ws2=%h want 10 a5a5 f 20 0", s_addr[63:32], s_wdata[63:32], s_wstrb[7:4], s_addr[95:64], s_wstrb[11:8]);
    end
    next_cycle();
    s_ready = 3'b110; s_rdata[63:32] = 32'h1111; s_rdata[95:64] = 32'h2222;
    #1 checks++;
    if ({m_ready, m_rdata} !== {2'b11, 32'h2222, 32'h1111}) begin
      errors++; $display("FAIL par_resp: got mr=%b rd=%h want mr=11 rd=0000222200001111", m_ready, m_rdata);
    end
  endtask

  task automatic test_miss();
    do_reset();
    next_cycle();
    m_valid = 2'b10; m_addr[63:32] = 32'h30000000; m_wstrb = '0;
    #1 checks++;
    if ({s_valid, m_ready} !== 5'b0) begin
      errors++; $display("FAIL miss_req: got sv=%b mr=%b want 0", s_valid, m_ready);
    end
    next_cycle();
    #1 checks++;
    if ({m_ready, m_err, m_rdata[63:32], s_valid} !== {2'b10, 2'b10, ERRD, 3'b000}) begin
      errors++; $display("FAIL miss_resp: got mr=%b me=%b rd=%h sv=%b want mr=10 me=10 rd=deadbeef sv=000", m_ready, m_err, m_rdata[63:32], s_valid);
    end
    next_cycle();
    #1 checks++;
    if ({m_ready, m_err} !== 4'b0) begin
      errors++; $display("FAIL miss_after: got mr=%b me=%b want 0", m_ready, m_err);
    end
  endtask

  task automatic test_alias();
    do_reset();
    next_cycle();
    m_valid = 2'b01; m_addr[31:0] = ALIAS; m_wdata[31:0] = 32'h55; m_wstrb[3:0] = 4'hF;
    #1 checks++;
    if ({s_valid, s_addr[63:32], s_wdata[63:32], s_wstrb[7:4]} !== {3'b010, 32'h7E001000, 32'h55, 4'hF}) begin
      errors++; $display("FAIL alias_req: got sv=%b sa=%h wd=%h ws=%h want 010 7e001000 55 f", s_valid, s_addr[63:32], s_wdata[63:32], s_wstrb[7:4]);
    end
    next_cycle();
    s_ready = 3'b010; s_rdata[63:32] = 32'h77;
    #1 checks++;
    if ({m_ready, m_err, m_rdata[31:0]} !== {2'b01, 2'b00, 32'h77}) begin
      errors++; $display("FAIL alias_resp: got mr=%b me=%b rd=%h want 01 00 77", m_ready, m_err, m_rdata[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    next_cycle();
    m_valid = 2'b01; m_addr[31:0] = 32'h100; m_wstrb = '0;
    #1 checks++;
    if (s_valid !== 3'b001) begin
      errors++; $display("FAIL rmid_req: got sv=%b want 001", s_valid);
    end
    next_cycle();
    reset = 1'b1; s_ready = 3'b001; s_rdata[31:0] = 32'hCAFE; m_valid = 2'b10; m_addr[63:32] = 32'h200;
    #1 checks++;
    if ({s_valid, m_ready, m_err, m_rdata, s_addr, s_wdata, s_wstrb, s_instr} !== '0) begin
      errors++; $display("FAIL rmid_zero: got sv=%b mr=%b me=%b rd=%h want all 0", s_valid, m_ready, m_err, m_rdata);
    end
    next_cycle();
    reset = 1'b0; s_ready = 3'b001;
    #1 checks++;
    if ({m_ready, s_valid} !== 5'b0) begin
      errors++; $display("FAIL rmid_late: got mr=%b sv=%b want 0", m_ready, s_valid);
    end
    next_cycle();
    m_valid = 2'b10; m_addr[63:32] = 32'h300;
    #1 checks++;
    if ({s_valid, s_addr[31:0]} !== {3'b001, 32'h300}) begin
      errors++; $display("FAIL rmid_free: got sv=%b sa=%h want 001 300", s_valid, s_addr[31:0]);
    end
    for (int s = 0; s < NS; s++) ptr[s] = NM-1;
  endtask

  task automatic test_random();
    int tgt [NM];
    logic [31:0] sa [NM];
    logic [31:0] wd [NM];
    logic [3:0] ws [NM];
    logic ins [NM];
    bit act [NM];
    int q [NS][$];
    int own [NS];
    int cnt [NS];
    logic [31:0] rd;
    logic [NS-1:0] exp_sv;
    logic [NM-1:0] exp_mr, exp_er;
    logic [31:0] exp_rd [NM];
    logic [31:0] a;
    int i;
    bit done;
    do_reset();
    repeat (80) begin
      next_cycle();
      for (int m = 0; m < NM; m++) begin
        act[m] = $urandom_range(0, 3) != 0;
        case ($urandom_range(0, 4))
          0: a = {12'h000, 20'($urandom)};
          1: a = {16'h0200, 16'($urandom)};
          2: a = {20'h10000, 12'($urandom)};
          3: a = {4'h3, 28'($urandom)};
          default: a = ALIAS;
        endcase
        wd[m] = $urandom;
        ws[m] = 4'($urandom);
        ins[m] = 1'($urandom);
        tgt[m] = -1;
        if (a == ALIAS) tgt[m] = 1;
        else for (int s = 0; s < NS; s++) if (tgt[m] < 0 && (a & mask[s]) == base[s]) tgt[m] = s;
        sa[m] = tgt[m] >= 0 ? a - base[tgt[m]] : 32'h0;
        m_valid[m] = act[m];
        m_addr[m*32 +: 32] = a;
        m_wdata[m*32 +: 32] = wd[m];
        m_wstrb[m*4 +: 4] = ws[m];
        m_instr[m] = ins[m];
      end
      for (int s = 0; s < NS; s++) begin
        q[s].delete();
        own[s] = -1;
        cnt[s] = 0;
        for (int k = 1; k <= NM; k++) begin
          i = (ptr[s] + k) % NM;
          if (act[i] && tgt[i] == s) q[s].push_back(i);
        end
      end
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        if (c > 0) next_cycle();
        exp_sv = '0;
        exp_mr = '0;
        exp_er = '0;
        for (int s = 0; s < NS; s++) begin
          if (own[s] >= 0) begin
            cnt[s]--;
            if (cnt[s] == 0) begin
              rd = $urandom;
              s_ready[s] = 1'b1;
              s_rdata[s*32 +: 32] = rd;
              exp_mr[own[s]] = 1'b1;
              exp_rd[own[s]] = rd;
              own[s] = -1;
            end
          end
        end
        for (int m = 0; m < NM; m++) begin
          if (c == 1 && act[m] && tgt[m] < 0) begin
            exp_mr[m] = 1'b1;
            exp_er[m] = 1'b1;
            exp_rd[m] = ERRD;
          end
        end
        #1;
        for (int s = 0; s < NS; s++) begin
          if (own[s] < 0 && q[s].size() > 0) begin
            i = q[s].pop_front();
            own[s] = i;
            ptr[s] = i;
            cnt[s] = $urandom_range(1, 3);
            exp_sv[s] = 1'b1;
            checks++;
            if ({s_addr[s*32 +: 32], s_wdata[s*32 +: 32], s_wstrb[s*4 +: 4], s_instr[s]} !== {sa[i], wd[i], ws[i], ins[i]}) begin
              errors++; $display("FAIL rnd_fields s%0d: got sa=%h wd=%h ws=%h si=%b want m%0d sa=%h wd=%h ws=%h si=%b",
                s, s_addr[s*32 +: 32], s_wdata[s*32 +: 32], s_wstrb[s*4 +: 4], s_instr[s], i, sa[i], wd[i], ws[i], ins[i]);
            end
          end
        end
        checks++;
        if ({s_valid, m_ready, m_err} !== {exp_sv, exp_mr, exp_er}) begin
          errors++; $display("FAIL rnd_ctrl c%0d: got sv=%b mr=%b me=%b want sv=%b mr=%b me=%b", c, s_valid, m_ready, m_err, exp_sv, exp_mr, exp_er);
        end
        for (int m = 0; m < NM; m++) begin
          if (exp_mr[m]) begin
            checks++;
            if (m_rdata[m*32 +: 32] !== exp_rd[m]) begin
              errors++; $display("FAIL rnd_rdata m%0d: got %h want %h", m, m_rdata[m*32 +: 32], exp_rd[m]);
            end
          end
        end
        done = c >= 1;
        for (int s = 0; s < NS; s++) if (own[s] >= 0 || q[s].size() > 0) done = 1'b0;
      end
      checks++;
      if (!done) begin
        errors++; $display("FAIL rnd_timeout: round did not drain within 40 cycles");
      end
    end
  endtask

  initial begin
    m_valid = '0; m_instr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata = '0; s_ready = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_parallel();
    test_miss();
    test_alias();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
